multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller and its datapath and memories.
// The master side is the controller; the slave side is the datapath/memory environment.
interface multicycle_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       func7;
   logic       imem_ready;
   logic       dmem_ready;

   logic       imem_req;
   logic       ir_we;
   logic       dmem_req;
   logic       dmem_we;
   logic       pc_we;
   logic       RegWrite;
   logic       MemtoReg;
   logic       ALUSrc;
   logic       lui;
   logic       U_type;
   logic       jal;
   logic       jalr;
   logic       beq;
   logic       bne;
   logic       blt;
   logic       bge;
   logic       bltu;
   logic       bgeu;
   logic [3:0] ALUctl;
   logic       illegal;
   logic       retire;
   logic [2:0] state;

   modport master (
      input  opcode, func3, func7, imem_ready, dmem_ready,
      output imem_req, ir_we, dmem_req, dmem_we, pc_we, RegWrite, MemtoReg, ALUSrc, lui,
             U_type, jal, jalr, beq, bne, blt, bge, bltu, bgeu, ALUctl, illegal, retire, state
   );

   modport slave (
      output opcode, func3, func7, imem_ready, dmem_ready,
      input  imem_req, ir_we, dmem_req, dmem_we, pc_we, RegWrite, MemtoReg, ALUSrc, lui,
             U_type, jal, jalr, beq, bne, blt, bge, bltu, bgeu, ALUctl, illegal, retire, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM: fetch/decode/execute/memory/writeback sequencing,
// registered decode controls and a sticky illegal-opcode trap.
module multicycle_ctrl (
   input logic           clk,
   input logic           rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd7
   } state_e;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpIAlu   = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b0001;
   localparam logic [3:0] AluAnd  = 4'b0010;
   localparam logic [3:0] AluOr   = 4'b0011;
   localparam logic [3:0] AluXor  = 4'b0100;
   localparam logic [3:0] AluSll  = 4'b0101;
   localparam logic [3:0] AluSrl  = 4'b0110;
   localparam logic [3:0] AluSra  = 4'b0111;
   localparam logic [3:0] AluSlt  = 4'b1000;
   localparam logic [3:0] AluSltu = 4'b1001;

   typedef struct packed {
      logic       mem_to_reg;
      logic       alu_src;
      logic       lui;
      logic       u_type;
      logic       jal;
      logic       jalr;
      logic [5:0] br;  // {beq, bne, blt, bge, bltu, bgeu}
      logic [3:0] alu;
   } ctl_t;

   typedef struct packed {
      logic load;
      logic store;
      logic branch;
   } cls_t;

   state_e state_q, state_d;
   logic   run_q;
   logic   illegal_q;
   ctl_t   ctl_q, dec_ctl;
   cls_t   cls_q, dec_cls;
   logic   dec_legal;

   // alt selects SUB (func3 000) or SRA (func3 101); it is ignored for every other func3.
   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? AluSub : AluAdd;
         3'b001:  op = AluSll;
         3'b010:  op = AluSlt;
         3'b011:  op = AluSltu;
         3'b100:  op = AluXor;
         3'b101:  op = alt ? AluSra : AluSrl;
         3'b110:  op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

   always_comb begin
      dec_ctl   = '0;
      dec_cls   = '0;
      dec_legal = 1'b1;
      case (bus.opcode)
         OpR: dec_ctl.alu = alu_of(bus.func3, bus.func7);
         OpIAlu: begin
            dec_ctl.alu_src = 1'b1;
            dec_ctl.alu     = alu_of(bus.func3, bus.func7 && (bus.func3 == 3'b101));
         end
         OpLoad: begin
            dec_ctl.mem_to_reg = 1'b1;
            dec_ctl.alu_src    = 1'b1;
            dec_cls.load       = 1'b1;
         end
         OpStore: begin
            dec_ctl.alu_src = 1'b1;
            dec_cls.store   = 1'b1;
         end
         OpBranch: begin
            dec_cls.branch = 1'b1;
            dec_ctl.alu    = bus.func3[1] ? AluSltu : AluSub;
            case (bus.func3)
               3'b000:  dec_ctl.br = 6'b100000;
               3'b001:  dec_ctl.br = 6'b010000;
               3'b100:  dec_ctl.br = 6'b001000;
               3'b101:  dec_ctl.br = 6'b000100;
               3'b110:  dec_ctl.br = 6'b000010;
               3'b111:  dec_ctl.br = 6'b000001;
               default: dec_legal = 1'b0;
            endcase
         end
         OpJal: dec_ctl.jal = 1'b1;
         OpJalr: begin
            dec_ctl.jalr    = 1'b1;
            dec_ctl.alu_src = 1'b1;
         end
         OpLui: begin
            dec_ctl.lui    = 1'b1;
            dec_ctl.u_type = 1'b1;
         end
         OpAuipc: dec_ctl.u_type = 1'b1;
         default: dec_legal = 1'b0;
      endcase
      // An unsupported instruction leaves no datapath selects behind.
      if (!dec_legal) begin
         dec_ctl = '0;
         dec_cls = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (run_q) state_d = StFetch;
         StFetch:  if (bus.imem_ready) state_d = StDecode;
         StDecode: state_d = dec_legal ? StExec : StTrap;
         StExec: begin
            if (cls_q.load || cls_q.store) state_d = StMem;
            else if (cls_q.branch)         state_d = StFetch;
            else                           state_d = StWb;
         end
         StMem:    if (bus.dmem_ready) state_d = cls_q.load ? StWb : StFetch;
         StWb:     state_d = StFetch;
         StTrap:   state_d = StTrap;
         default:  state_d = StIdle;
      endcase
   end

   // run_q delays leaving IDLE by one edge so the FSM never moves on the edge right after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         run_q     <= 1'b0;
         illegal_q <= 1'b0;
         ctl_q     <= '0;
         cls_q     <= '0;
      end else begin
         run_q   <= 1'b1;
         state_q <= state_d;
         if (state_q == StDecode) begin
            ctl_q <= dec_ctl;
            cls_q <= dec_cls;
            if (!dec_legal) illegal_q <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.imem_req = (state_q == StFetch);
      bus.ir_we    = (state_q == StFetch) && bus.imem_ready;
      bus.dmem_req = (state_q == StMem);
      bus.dmem_we  = (state_q == StMem) && cls_q.store;
      bus.RegWrite = (state_q == StWb);
      bus.pc_we    = (state_q == StWb)
                  || ((state_q == StExec) && cls_q.branch)
                  || ((state_q == StMem) && bus.dmem_ready && cls_q.store);
      bus.retire   = bus.pc_we;
   end

   assign bus.state    = state_q;
   assign bus.illegal  = illegal_q;
   assign bus.MemtoReg = ctl_q.mem_to_reg;
   assign bus.ALUSrc   = ctl_q.alu_src;
   assign bus.lui      = ctl_q.lui;
   assign bus.U_type   = ctl_q.u_type;
   assign bus.jal      = ctl_q.jal;
   assign bus.jalr     = ctl_q.jalr;
   assign bus.beq      = ctl_q.br[5];
   assign bus.bne      = ctl_q.br[4];
   assign bus.blt      = ctl_q.br[3];
   assign bus.bge      = ctl_q.br[2];
   assign bus.bltu     = ctl_q.br[1];
   assign bus.bgeu     = ctl_q.br[0];
   assign bus.ALUctl   = ctl_q.alu;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle
// trace from the instruction class and memory wait counts, then compared every cycle.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_to_reg, alu_src, lui, u_type, jal, jalr;
      logic [5:0] br;  // {beq, bne, blt, bge, bltu, bgeu}
      logic [3:0] alu;
   } ctl_t;

   typedef struct {
      bit   legal;
      int   kind;  // 0 alu/jump/upper, 1 load, 2 store, 3 branch
      ctl_t ctl;
   } dec_t;

   typedef struct {
      logic [2:0] st;
      logic imem_req, ir_we, dmem_req, dmem_we, pc_we, regw, illegal;
      ctl_t ctl;
      bit   chk_ctl;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   vectors    = 0;
   int   miscompares = 0;
   rec_t exp_q[$];
   ctl_t cur_ctl     = '0;
   bit   cur_illegal = 1'b0;
   int   lat_expect  = 0;

   // Reference decode, written as tables over the instruction set.
   function automatic dec_t model_dec(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      dec_t d;
      logic [3:0] ftab [8];
      ftab = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
      d.legal = 1'b1;
      d.kind  = 0;
      d.ctl   = '0;
      if (op == 7'b0110011) begin
         d.ctl.alu = ftab[f3];
         if (f7 && f3 == 3'd0) d.ctl.alu = 4'b0001;
         if (f7 && f3 == 3'd5) d.ctl.alu = 4'b0111;
      end else if (op == 7'b0010011) begin
         d.ctl.alu_src = 1'b1;
         d.ctl.alu = (f7 && f3 == 3'd5) ? 4'b0111 : ftab[f3];
      end else if (op == 7'b0000011) begin
         d.kind = 1; d.ctl.mem_to_reg = 1'b1; d.ctl.alu_src = 1'b1;
      end else if (op == 7'b0100011) begin
         d.kind = 2; d.ctl.alu_src = 1'b1;
      end else if (op == 7'b1100011) begin
         d.kind = 3;
         case (f3)
            3'd0: d.ctl.br = 6'b100000;
            3'd1: d.ctl.br = 6'b010000;
            3'd4: d.ctl.br = 6'b001000;
            3'd5: d.ctl.br = 6'b000100;
            3'd6: d.ctl.br = 6'b000010;
            3'd7: d.ctl.br = 6'b000001;
            default: d.legal = 1'b0;
         endcase
         d.ctl.alu = (f3 >= 3'd6) ? 4'b1001 : 4'b0001;
      end else if (op == 7'b1101111) begin
         d.ctl.jal = 1'b1;
      end else if (op == 7'b1100111) begin
         d.ctl.jalr = 1'b1; d.ctl.alu_src = 1'b1;
      end else if (op == 7'b0110111) begin
         d.ctl.lui = 1'b1; d.ctl.u_type = 1'b1;
      end else if (op == 7'b0010111) begin
         d.ctl.u_type = 1'b1;
      end else begin
         d.legal = 1'b0;
      end
      if (!d.legal) d.ctl = '0;
      return d;
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic rec_t mk(input logic [2:0] st);
      rec_t r;
      r = '{st: st, imem_req: 0, ir_we: 0, dmem_req: 0, dmem_we: 0, pc_we: 0, regw: 0,
            illegal: cur_illegal, ctl: cur_ctl, chk_ctl: 1'b1};
      return r;
   endfunction

   task automatic step(input rec_t r, input logic rs, input logic imr, input logic dmr,
                       input bit vis, input logic [6:0] op, input logic [2:0] f3, input logic f7);
      logic [10:0] junk;
      @(posedge clk);
      #1;
      junk = 11'($urandom);
      rst = rs;
      bus.imem_ready = imr;
      bus.dmem_ready = dmr;
      {bus.opcode, bus.func3, bus.func7} = vis ? {op, f3, f7} : junk;
      exp_q.push_back(r);
   endtask

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic do_reset();
      rec_t r;
      cur_ctl = '0;
      cur_illegal = 1'b0;
      r = mk(3'd0);
      for (int i = 0; i < 2; i++) step(r, 1'b1, rb(), rb(), 0, 0, 0, 0);
      // Release cycle plus one more IDLE cycle before FETCH.
      for (int i = 0; i < 2; i++) step(r, 1'b0, rb(), rb(), 0, 0, 0, 0);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int iw, input int dw, input int rst_mem);
      dec_t d;
      rec_t r;
      d = model_dec(op, f3, f7);
      for (int i = 0; i < iw; i++) begin
         r = mk(3'd1); r.imem_req = 1;
         step(r, 0, 1'b0, rb(), 0, op, f3, f7);
      end
      r = mk(3'd1); r.imem_req = 1; r.ir_we = 1;
      step(r, 0, 1'b1, rb(), 0, op, f3, f7);
      r = mk(3'd2);
      step(r, 0, rb(), rb(), 1, op, f3, f7);
      if (!d.legal) begin
         cur_illegal = 1'b1;
         for (int i = 0; i < 20; i++) begin
            r = mk(3'd7); r.chk_ctl = 1'b0;
            step(r, 0, rb(), rb(), 0, op, f3, f7);
         end
         do_reset();
         return;
      end
      cur_ctl = d.ctl;
      r = mk(3'd3); r.pc_we = (d.kind == 3);
      step(r, 0, rb(), rb(), 0, op, f3, f7);
      if (d.kind == 3) return;
      if (d.kind == 1 || d.kind == 2) begin
         for (int j = 0; j < dw; j++) begin
            if (rst_mem == j) begin
               do_reset();
               return;
            end
            r = mk(3'd4); r.dmem_req = 1; r.dmem_we = (d.kind == 2);
            step(r, 0, rb(), 1'b0, 0, op, f3, f7);
         end
         r = mk(3'd4); r.dmem_req = 1; r.dmem_we = (d.kind == 2); r.pc_we = (d.kind == 2);
         step(r, 0, rb(), 1'b1, 0, op, f3, f7);
         if (d.kind == 2) return;
      end
      r = mk(3'd5); r.regw = 1; r.pc_we = 1;
      step(r, 0, rb(), rb(), 0, op, f3, f7);
   endtask

   // Single compare process: per-cycle trace check plus FETCH-to-retire latency on directed runs.
   initial begin
      rec_t e;
      logic [10:0] act_s, exp_s;
      logic [15:0] act_c;
      logic prev_imem = 1'b0;
      int   lat_cnt = 0;
      int   lat_cur = 0;
      forever begin
         @(negedge clk);
         if (bus.imem_req && !prev_imem) begin
            lat_cnt = 1;
            lat_cur = lat_expect;
         end else if (lat_cnt > 0) begin
            lat_cnt++;
         end
         prev_imem = bus.imem_req;
         if (bus.retire && lat_cur != 0) begin
            check("latency", 16'(lat_cnt), 16'(lat_cur));
            lat_cur = 0;
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_s = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.pc_we,
                     bus.RegWrite, bus.illegal, bus.retire};
            exp_s = {e.st, e.imem_req, e.ir_we, e.dmem_req, e.dmem_we, e.pc_we, e.regw,
                     e.illegal, e.pc_we};
            act_c = {bus.MemtoReg, bus.ALUSrc, bus.lui, bus.U_type, bus.jal, bus.jalr, bus.beq,
                     bus.bne, bus.blt, bus.bge, bus.bltu, bus.bgeu, bus.ALUctl};
            vectors++;
            if (act_s !== exp_s || (e.chk_ctl && act_c !== 16'(e.ctl))) begin
               miscompares++;
               $display("FAIL cycle t=%0t: status got %b want %b, controls got %h want %h",
                        $time, act_s, exp_s, act_c, 16'(e.ctl));
            end
         end
      end
   end

   initial begin
      dec_t d;
      logic [6:0] ops [9];
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      int         dw, rm;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      bus.opcode = '0; bus.func3 = '0; bus.func7 = 1'b0;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

      // Hand-computed pins on the reference decode.
      d = model_dec(7'b0110011, 3'b000, 1'b0); check("add_alu", 16'(d.ctl.alu), 16'h0000);
      d = model_dec(7'b0110011, 3'b000, 1'b1); check("sub_alu", 16'(d.ctl.alu), 16'h0001);
      d = model_dec(7'b1100011, 3'b110, 1'b0); check("bltu_ctl", 16'(d.ctl), 16'h0029);
      d = model_dec(7'b0010011, 3'b000, 1'b1); check("addi_alu", 16'(d.ctl.alu), 16'h0000);
      d = model_dec(7'b0010011, 3'b101, 1'b1); check("srai_alu", 16'(d.ctl.alu), 16'h0007);
      d = model_dec(7'b0000011, 3'b010, 1'b0); check("lw_ctl", 16'(d.ctl), 16'hC000);
      d = model_dec(7'b0000000, 3'b000, 1'b0); check("op0_legal", 16'(d.legal), 16'h0000);
      d = model_dec(7'b1100011, 3'b010, 1'b0); check("br010_legal", 16'(d.legal), 16'h0000);

      do_reset();
      // Directed zero-wait runs with literal FETCH-to-retire latencies.
      lat_expect = 4; run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, -1);  // ADD x3,x1,x2
      lat_expect = 5; run_instr(7'b0000011, 3'b010, 1'b0, 0, 0, -1);  // LW
      lat_expect = 4; run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, -1);  // SW
      lat_expect = 3; run_instr(7'b1100011, 3'b110, 1'b0, 0, 0, -1);  // BLTU
      lat_expect = 4; run_instr(7'b1101111, 3'b000, 1'b0, 0, 0, -1);  // JAL
      lat_expect = 4; run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, -1);  // LUI
      lat_expect = 0;
      run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, -1);  // LW, dmem_ready delayed 3
      run_instr(7'b0100011, 3'b010, 1'b0, 2, 2, -1);  // SW with waits
      run_instr(7'b0000011, 3'b010, 1'b0, 0, 4, 2);   // reset mid-MEM
      run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, -1);  // illegal opcode -> TRAP, then reset
      run_instr(7'b1100011, 3'b011, 1'b0, 1, 0, -1);  // illegal branch func3

      for (int n = 0; n < 250; n++) begin
         f3 = 3'($urandom);
         f7 = rb();
         op = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 99) < 6) begin
            do op = 7'($urandom); while (model_dec(op, f3, f7).legal);
         end else if (op == 7'b1100011) begin
            while (f3 == 3'd2 || f3 == 3'd3) f3 = 3'($urandom);
         end
         dw = $urandom_range(0, 3);
         rm = ($urandom_range(0, 99) < 5 && dw > 0) ? $urandom_range(0, dw - 1) : -1;
         run_instr(op, f3, f7, $urandom_range(0, 3), dw, rm);
      end

      while (exp_q.size() > 0) @(posedge clk);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
